// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared sizes, FSM states, key-bit map and key-count classifier for the keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = NUM_ROWS * NUM_COLS;
    localparam int COL_W    = $clog2(NUM_COLS);

    // Digit key positions on the one-hot bus (bit = 4*row + col)
    localparam int KEY_D0 = 3;
    localparam int KEY_D1 = 7;
    localparam int KEY_D2 = 6;
    localparam int KEY_D3 = 5;
    localparam int KEY_D4 = 11;
    localparam int KEY_D5 = 10;
    localparam int KEY_D6 = 9;
    localparam int KEY_D7 = 15;
    localparam int KEY_D8 = 14;
    localparam int KEY_D9 = 13;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        MULTI    = 2'd2
    } key_state_e;

    typedef enum logic [1:0] {
        KC_ZERO = 2'd0,
        KC_ONE  = 2'd1,
        KC_MANY = 2'd2
    } key_class_e;

    // Clearing the lowest set bit leaves zero only when exactly one bit was set
    function automatic key_class_e key_class(input logic [KEY_W-1:0] v);
        if (v == '0) begin
            return KC_ZERO;
        end
        if ((v & (v - KEY_W'(1))) == '0) begin
            return KC_ONE;
        end
        return KC_MANY;
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// rtl/keypad_col_scanner.sv - row synchroniser, column strobe sequencer and per-frame key snapshot assembly
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_ROWS-1:0] row_n_i,
    output logic [NUM_COLS-1:0] col_n_o,
    output logic [KEY_W-1:0]    frame_o,
    output logic                frame_done_o
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] row_sync_q;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [KEY_W-1:0]    snap_q, snap_d;
    logic                slot_last;

    always_comb begin
        slot_last = (slot_q == SLOT_LAST);
        slot_d    = slot_last ? '0 : slot_q + SLOT_W'(1);
        col_d     = col_q;
        col_n_d   = col_n_q;
        snap_d    = snap_q;
        if (slot_last) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                snap_d[r*NUM_COLS + int'(col_q)] = ~row_sync_q[r];
            end
            // Strobe moves on the sampling edge so the next column gets the full slot to settle
            col_d   = col_q + COL_W'(1);
            col_n_d = ~(NUM_COLS'(1) << col_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            slot_q     <= '0;
            col_q      <= '0;
            col_n_q    <= ~NUM_COLS'(1);
            snap_q     <= '0;
        end else begin
            row_meta_q <= row_n_i;
            row_sync_q <= row_meta_q;
            slot_q     <= slot_d;
            col_q      <= col_d;
            col_n_q    <= col_n_d;
            snap_q     <= snap_d;
        end
    end

    assign col_n_o      = col_n_q;
    assign frame_o      = snap_d;
    assign frame_done_o = slot_last && (col_q == COL_LAST);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - 4x4 keypad scanner: whole-frame debounce and press FSM driving the one-hot key bus
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [KEY_W-1:0]    onehot,
    output logic                key_valid,
    output logic                key_held,
    output logic                multi_key
);

    localparam int                STAB_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_FRAMES);

    logic [KEY_W-1:0]  frame;
    logic              frame_done;
    logic              frame_stable;
    key_class_e        frame_class;

    logic [KEY_W-1:0]  prev_q, prev_d;
    logic [STAB_W-1:0] stable_q, stable_d;
    key_state_e        state_q, state_d;
    logic [KEY_W-1:0]  onehot_q, onehot_d;
    logic              key_valid_q, key_valid_d;
    logic              held_q, held_d;
    logic              multi_q, multi_d;

    keypad_col_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scanner (
        .clk_i        (clk),
        .rst_i        (rst),
        .row_n_i      (row_n),
        .col_n_o      (col_n),
        .frame_o      (frame),
        .frame_done_o (frame_done)
    );

    always_comb begin
        prev_d       = prev_q;
        stable_d     = stable_q;
        frame_stable = 1'b0;
        if (frame_done) begin
            if (frame == prev_q) begin
                stable_d = (stable_q == STAB_MAX) ? STAB_MAX : stable_q + STAB_W'(1);
            end else begin
                stable_d = STAB_W'(1);
            end
            prev_d       = frame;
            frame_stable = (stable_d == STAB_MAX);
        end
    end

    always_comb begin
        state_d     = state_q;
        onehot_d    = onehot_q;
        key_valid_d = 1'b0;
        multi_d     = multi_q;
        frame_class = key_class(frame);
        if (frame_stable) begin
            unique case (state_q)
                RELEASED: begin
                    if (frame_class == KC_ONE) begin
                        state_d     = PRESSED;
                        onehot_d    = frame;
                        key_valid_d = 1'b1;
                    end else if (frame_class == KC_MANY) begin
                        state_d = MULTI;
                        multi_d = 1'b1;
                    end
                end
                PRESSED: begin
                    // A roll-over to another key goes through MULTI so it never pulses
                    if (frame != onehot_q) begin
                        onehot_d = '0;
                        if (frame_class == KC_ZERO) begin
                            state_d = RELEASED;
                        end else begin
                            state_d = MULTI;
                            multi_d = 1'b1;
                        end
                    end
                end
                MULTI: begin
                    if (frame_class == KC_ZERO) begin
                        state_d = RELEASED;
                        multi_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = RELEASED;
                    onehot_d = '0;
                    multi_d  = 1'b0;
                end
            endcase
        end
        held_d = (state_d == PRESSED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= '0;
            stable_q    <= '0;
            state_q     <= RELEASED;
            onehot_q    <= '0;
            key_valid_q <= 1'b0;
            held_q      <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            state_q     <= state_d;
            onehot_q    <= onehot_d;
            key_valid_q <= key_valid_d;
            held_q      <= held_d;
            multi_q     <= multi_d;
        end
    end

    assign onehot    = onehot_q;
    assign key_valid = key_valid_q;
    assign key_held  = held_q;
    assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - keypad scanner bench: switch-matrix model plus frame-level debounce/press reference
module tb_keypad_matrix_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DF       = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;
    logic [15:0] keys = 16'h0000;

    int total = 0;
    int bad   = 0;

    // Reference model state, one step per completed frame
    logic [15:0] m_prev;
    int          m_stable;
    logic        m_held;
    logic        m_multi;
    logic [15:0] m_onehot;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .onehot    (onehot),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    // Pressed switch at (r,c) shorts row r to column c
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic model_reset();
        m_prev   = 16'h0;
        m_stable = 0;
        m_held   = 1'b0;
        m_multi  = 1'b0;
        m_onehot = 16'h0;
    endtask

    task automatic model_frame(input logic [15:0] f, output int ep);
        ep = 0;
        if (f == m_prev) m_stable = (m_stable + 1 > DF) ? DF : m_stable + 1;
        else m_stable = 1;
        m_prev = f;
        if (m_stable == DF) begin
            if (m_held) begin
                if (f != m_onehot) begin
                    m_held   = 1'b0;
                    m_onehot = 16'h0;
                    m_multi  = (f != 16'h0);
                end
            end else if (m_multi) begin
                if (f == 16'h0) m_multi = 1'b0;
            end else if ($countones(f) == 1) begin
                m_held   = 1'b1;
                m_onehot = f;
                ep       = 1;
            end else if ($countones(f) > 1) begin
                m_multi = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Holds f for one whole frame starting just after a frame edge; returns what the DUT showed
    task automatic run_frame(input logic [15:0] f, output int pulses, output logic [15:0] oh,
                             output logic hd, output logic mk);
        keys   = f;
        pulses = 0;
        repeat (FRAME) begin
            @(posedge clk);
            #1;
            if (key_valid) pulses++;
        end
        oh = onehot;
        hd = key_held;
        mk = multi_key;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        keys = 16'h0;
        do_reset(3);
        total++;
        if (col_n !== 4'b1110) begin
            bad++;
            $display("FAIL reset_col_n: got %b want 1110", col_n);
        end
        total++;
        if (onehot !== 16'h0 || key_valid !== 1'b0 || key_held !== 1'b0 || multi_key !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got onehot=%h valid=%b held=%b multi=%b want 0", onehot, key_valid, key_held, multi_key);
        end
        for (int k = 1; k <= 2 * FRAME; k++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            total++;
            if (col_n !== exp_col) begin
                bad++;
                $display("FAIL col_walk cycle %0d: got %b want %b", k, col_n, exp_col);
            end
        end
    endtask

    task automatic test_single_press();
        int p, ep, sum;
        logic [15:0] oh;
        logic hd, mk, f;
        do_reset(2);
        sum = 0;
        for (int i = 0; i < 13; i++) begin
            run_frame((i < 10) ? 16'h0008 : 16'h0000, p, oh, hd, mk);
            model_frame((i < 10) ? 16'h0008 : 16'h0000, ep);
            if (i < 10) sum += p;
            total++;
            if (p != ep || oh !== m_onehot || hd !== m_held || mk !== m_multi) begin
                bad++;
                $display("FAIL single frame %0d: got p=%0d oh=%h held=%b multi=%b want p=%0d oh=%h held=%b multi=%b",
                         i, p, oh, hd, mk, ep, m_onehot, m_held, m_multi);
            end
            if (i == 2) begin
                total++;
                if (oh !== 16'h0008 || hd !== 1'b1) begin
                    bad++;
                    $display("FAIL single_latency: got oh=%h held=%b want 0008 1", oh, hd);
                end
            end
        end
        total++;
        if (sum != 1) begin
            bad++;
            $display("FAIL single_pulse_count: got %0d want 1", sum);
        end
    endtask

    task automatic test_bounce();
        int p, sum, nz;
        logic [15:0] oh;
        logic hd, mk;
        do_reset(2);
        run_frame(16'h0, p, oh, hd, mk);
        run_frame(16'h0, p, oh, hd, mk);
        keys = 16'h0100;
        sum  = 0;
        nz   = 0;
        for (int k = 1; k <= 4 * FRAME; k++) begin
            @(posedge clk);
            #1;
            if (key_valid) sum++;
            if (onehot !== 16'h0) nz++;
            if (k % 5 == 0) keys = keys ^ 16'h0100;
        end
        total++;
        if (sum != 0 || nz != 0) begin
            bad++;
            $display("FAIL bounce_toggling: got pulses=%0d nonzero_cycles=%0d want 0 0", sum, nz);
        end
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            run_frame(16'h0100, p, oh, hd, mk);
            sum += p;
        end
        total++;
        if (sum != 1 || oh !== 16'h0100 || hd !== 1'b1) begin
            bad++;
            $display("FAIL bounce_hold: got pulses=%0d oh=%h held=%b want 1 0100 1", sum, oh, hd);
        end
        for (int i = 0; i < 3; i++) run_frame(16'h0, p, oh, hd, mk);
        total++;
        if (oh !== 16'h0 || hd !== 1'b0) begin
            bad++;
            $display("FAIL bounce_release: got oh=%h held=%b want 0000 0", oh, hd);
        end
    endtask

    task automatic test_two_keys();
        int p, ep;
        logic [15:0] oh, f;
        logic hd, mk;
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            f = (i < 4) ? 16'h4020 : 16'h0000;
            run_frame(f, p, oh, hd, mk);
            model_frame(f, ep);
            total++;
            if (p != ep || oh !== m_onehot || hd !== m_held || mk !== m_multi) begin
                bad++;
                $display("FAIL two_keys frame %0d: got p=%0d oh=%h held=%b multi=%b want p=%0d oh=%h held=%b multi=%b",
                         i, p, oh, hd, mk, ep, m_onehot, m_held, m_multi);
            end
            if (i == 3) begin
                total++;
                if (mk !== 1'b1 || oh !== 16'h0) begin
                    bad++;
                    $display("FAIL two_keys_multi: got multi=%b oh=%h want 1 0000", mk, oh);
                end
            end
        end
    endtask

    task automatic test_rollover();
        logic [15:0] seq_f [5] = '{16'h0080, 16'h00C0, 16'h0040, 16'h0000, 16'h0040};
        int          seq_n [5] = '{4, 2, 4, 3, 4};
        int p, ep;
        logic [15:0] oh;
        logic hd, mk;
        do_reset(2);
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < seq_n[s]; i++) begin
                run_frame(seq_f[s], p, oh, hd, mk);
                model_frame(seq_f[s], ep);
                total++;
                if (p != ep || oh !== m_onehot || hd !== m_held || mk !== m_multi) begin
                    bad++;
                    $display("FAIL rollover seg %0d frame %0d: got p=%0d oh=%h held=%b multi=%b want p=%0d oh=%h held=%b multi=%b",
                             s, i, p, oh, hd, mk, ep, m_onehot, m_held, m_multi);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int p, ep, sum;
        logic [15:0] oh;
        logic hd, mk;
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            run_frame(16'h2000, p, oh, hd, mk);
            model_frame(16'h2000, ep);
        end
        total++;
        if (oh !== 16'h2000 || hd !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pre: got oh=%h held=%b want 2000 1", oh, hd);
        end
        repeat (7) @(posedge clk);
        #1;
        do_reset(1);
        total++;
        if (onehot !== 16'h0 || key_valid !== 1'b0 || key_held !== 1'b0 || multi_key !== 1'b0 || col_n !== 4'b1110) begin
            bad++;
            $display("FAIL midreset_clear: got onehot=%h valid=%b held=%b multi=%b col=%b want 0 0 0 0 1110",
                     onehot, key_valid, key_held, multi_key, col_n);
        end
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            run_frame(16'h2000, p, oh, hd, mk);
            model_frame(16'h2000, ep);
            sum += p;
            total++;
            if (p != ep || oh !== m_onehot || hd !== m_held || mk !== m_multi) begin
                bad++;
                $display("FAIL midreset frame %0d: got p=%0d oh=%h held=%b multi=%b want p=%0d oh=%h held=%b multi=%b",
                         i, p, oh, hd, mk, ep, m_onehot, m_held, m_multi);
            end
        end
        total++;
        if (sum != 1 || oh !== 16'h2000) begin
            bad++;
            $display("FAIL midreset_reaccept: got pulses=%0d oh=%h want 1 2000", sum, oh);
        end
    endtask

    task automatic test_random();
        int p, ep, n;
        logic [15:0] oh, f;
        logic hd, mk;
        do_reset(2);
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0:       f = 16'h0;
                1, 2:    f = 16'h1 << $urandom_range(0, 15);
                default: f = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                run_frame(f, p, oh, hd, mk);
                model_frame(f, ep);
                total++;
                if (p != ep || oh !== m_onehot || hd !== m_held || mk !== m_multi) begin
                    bad++;
                    $display("FAIL random seg %0d keys=%h: got p=%0d oh=%h held=%b multi=%b want p=%0d oh=%h held=%b multi=%b",
                             s, f, p, oh, hd, mk, ep, m_onehot, m_held, m_multi);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_rollover();
        test_reset_mid_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
